// File: rtl/ll_req_sequencer_pkg.sv
// Shared request/response encodings and widths for the list request sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ll_req_sequencer_pkg;

    localparam int PTR_WD     = 4;
    localparam int WR_DATA_WD = 8;

    typedef enum logic [1:0] {
        REQ_READ   = 2'd0,
        REQ_WRITE  = 2'd1,
        REQ_INSERT = 2'd2,
        REQ_DELETE = 2'd3
    } t_req_types;

    // RESP_TIMEOUT is generated locally by the sequencer watchdog, never by the list.
    typedef enum logic [1:0] {
        RESP_OK       = 2'd0,
        RESP_ERROR    = 2'd1,
        RESP_ADDR_ERR = 2'd2,
        RESP_TIMEOUT  = 2'd3
    } t_resp_types;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RET   = 2'd3
    } t_seq_state;

endpackage

// File: rtl/ll_req_fifo.sv
// Synchronous FIFO holding packed {type,pos,data,tag} request entries.
// Latency: an entry pushed this cycle is visible at the head the next cycle.
// Backpressure: push ignored while full, pop ignored while empty.
module ll_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ll_req_sequencer.sv
// Host front end for the linked list: queues tagged requests, issues one at a time, returns tagged responses.
// Latency: ll_req_vld 2 cycles after a push into an empty FIFO; host response 1 cycle after the list response.
// Backpressure: host_req_rdy = FIFO not full; issue waits on ll_intf_ready; RET holds until host_resp_rdy.
module ll_req_sequencer
    import ll_req_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WD     = 4,
    parameter int TMO_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req_vld,
    output logic                  host_req_rdy,
    input  t_req_types            host_req_type,
    input  logic [PTR_WD-1:0]     host_req_pos,
    input  logic [WR_DATA_WD-1:0] host_req_data,
    input  logic [TAG_WD-1:0]     host_req_tag,
    output logic                  ll_req_vld,
    output t_req_types            ll_req_type,
    output logic [PTR_WD-1:0]     ll_req_pos,
    output logic [WR_DATA_WD-1:0] ll_req_data,
    input  logic                  ll_intf_ready,
    input  logic                  ll_resp_vld,
    input  t_resp_types           ll_resp_type,
    input  logic [WR_DATA_WD-1:0] ll_resp_data,
    input  logic                  ll_resp_data_vld,
    output logic                  ll_resp_taken,
    output logic                  host_resp_vld,
    input  logic                  host_resp_rdy,
    output t_resp_types           host_resp_type,
    output logic [WR_DATA_WD-1:0] host_resp_data,
    output logic                  host_resp_data_vld,
    output logic [TAG_WD-1:0]     host_resp_tag,
    output logic                  busy
);

    localparam int ENT_WD = 2 + PTR_WD + WR_DATA_WD + TAG_WD;
    localparam int TW     = $clog2(TMO_CYCLES) + 1;

    t_seq_state            state;
    t_seq_state            state_nxt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [ENT_WD-1:0]     fifo_wr_dat;
    logic [ENT_WD-1:0]     fifo_rd_dat;
    logic [1:0]            head_type;
    logic [PTR_WD-1:0]     head_pos;
    logic [WR_DATA_WD-1:0] head_data;
    logic [TAG_WD-1:0]     head_tag;
    logic [TW-1:0]         timer;
    logic                  timeout;
    logic [TAG_WD-1:0]     tag_q;
    t_resp_types           resp_type_q;
    logic [WR_DATA_WD-1:0] resp_data_q;
    logic                  resp_data_vld_q;

    assign fifo_wr_dat = {host_req_type, host_req_pos, host_req_data, host_req_tag};
    assign {head_type, head_pos, head_data, head_tag} = fifo_rd_dat;

    ll_req_fifo #(
        .WIDTH (ENT_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (host_req_vld && host_req_rdy),
        .push_dat (fifo_wr_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Ready is forced low during reset so no request is accepted into a FIFO being cleared.
    assign host_req_rdy       = !fifo_full && !reset;
    // Any list response is consumed; outside WAIT it is simply dropped.
    assign ll_resp_taken      = ll_resp_vld && !reset;
    assign host_resp_type     = resp_type_q;
    assign host_resp_data     = resp_data_q;
    assign host_resp_data_vld = resp_data_vld_q;
    assign host_resp_tag      = tag_q;
    assign busy               = (state != ST_IDLE) || !fifo_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and per-state outputs; the timer is checked one count early so RET lands TMO_CYCLES after ISSUE.
    always_comb begin
        state_nxt     = state;
        fifo_pop      = 1'b0;
        ll_req_vld    = 1'b0;
        ll_req_type   = REQ_READ;
        ll_req_pos    = '0;
        ll_req_data   = '0;
        host_resp_vld = 1'b0;
        timeout       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && ll_intf_ready) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                ll_req_vld  = 1'b1;
                ll_req_type = t_req_types'(head_type);
                ll_req_pos  = head_pos;
                ll_req_data = head_data;
                fifo_pop    = 1'b1;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ll_resp_vld) begin
                    state_nxt = ST_RET;
                end else if (timer == TW'(TMO_CYCLES - 2)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RET;
                end
            end
            ST_RET: begin
                host_resp_vld = 1'b1;
                if (host_resp_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tag latch, watchdog timer and response capture; a real response takes priority over timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q           <= '0;
            timer           <= '0;
            resp_type_q     <= RESP_OK;
            resp_data_q     <= '0;
            resp_data_vld_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE) tag_q <= head_tag;
            if (state == ST_WAIT)  timer <= timer + 1'b1;
            else                   timer <= '0;
            if (state == ST_WAIT && ll_resp_vld) begin
                resp_type_q     <= ll_resp_type;
                resp_data_q     <= ll_resp_data;
                resp_data_vld_q <= ll_resp_data_vld;
            end else if (timeout) begin
                resp_type_q     <= RESP_TIMEOUT;
                resp_data_q     <= '0;
                resp_data_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ll_req_sequencer.sv
// Directed bench for ll_req_sequencer with a short watchdog (TMO_CYCLES=8).
// Latency: checks exact issue and response cycles.
// Backpressure: exercises FIFO full, ll_intf_ready low and host_resp_rdy low.
module tb_ll_req_sequencer;
    import ll_req_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  host_req_vld;
    logic                  host_req_rdy;
    t_req_types            host_req_type;
    logic [PTR_WD-1:0]     host_req_pos;
    logic [WR_DATA_WD-1:0] host_req_data;
    logic [3:0]            host_req_tag;
    logic                  ll_req_vld;
    t_req_types            ll_req_type;
    logic [PTR_WD-1:0]     ll_req_pos;
    logic [WR_DATA_WD-1:0] ll_req_data;
    logic                  ll_intf_ready;
    logic                  ll_resp_vld;
    t_resp_types           ll_resp_type;
    logic [WR_DATA_WD-1:0] ll_resp_data;
    logic                  ll_resp_data_vld;
    logic                  ll_resp_taken;
    logic                  host_resp_vld;
    logic                  host_resp_rdy;
    t_resp_types           host_resp_type;
    logic [WR_DATA_WD-1:0] host_resp_data;
    logic                  host_resp_data_vld;
    logic [3:0]            host_resp_tag;
    logic                  busy;

    int n_run  = 0;
    int n_fail = 0;

    ll_req_sequencer #(.FIFO_DEPTH(4), .TAG_WD(4), .TMO_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .host_req_vld(host_req_vld), .host_req_rdy(host_req_rdy),
        .host_req_type(host_req_type), .host_req_pos(host_req_pos),
        .host_req_data(host_req_data), .host_req_tag(host_req_tag),
        .ll_req_vld(ll_req_vld), .ll_req_type(ll_req_type),
        .ll_req_pos(ll_req_pos), .ll_req_data(ll_req_data),
        .ll_intf_ready(ll_intf_ready), .ll_resp_vld(ll_resp_vld),
        .ll_resp_type(ll_resp_type), .ll_resp_data(ll_resp_data),
        .ll_resp_data_vld(ll_resp_data_vld), .ll_resp_taken(ll_resp_taken),
        .host_resp_vld(host_resp_vld), .host_resp_rdy(host_resp_rdy),
        .host_resp_type(host_resp_type), .host_resp_data(host_resp_data),
        .host_resp_data_vld(host_resp_data_vld), .host_resp_tag(host_resp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input t_req_types t, input logic [PTR_WD-1:0] p,
                        input logic [WR_DATA_WD-1:0] d, input logic [3:0] tg);
        host_req_vld  = 1'b1;
        host_req_type = t;
        host_req_pos  = p;
        host_req_data = d;
        host_req_tag  = tg;
        step();
        host_req_vld  = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (ll_req_vld !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(name, ll_req_vld, 1);
    endtask

    task automatic respond(input t_resp_types t, input logic [WR_DATA_WD-1:0] d);
        ll_resp_vld      = 1'b1;
        ll_resp_type     = t;
        ll_resp_data     = d;
        ll_resp_data_vld = 1'b1;
        step();
        ll_resp_vld      = 1'b0;
        ll_resp_data_vld = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; host_req_vld = 1'b0; host_req_type = REQ_READ; host_req_pos = '0;
        host_req_data = '0; host_req_tag = '0; ll_intf_ready = 1'b0; ll_resp_vld = 1'b0;
        ll_resp_type = RESP_OK; ll_resp_data = '0; ll_resp_data_vld = 1'b0; host_resp_rdy = 1'b1;
        repeat (3) step();
        chk("rst_req_rdy", host_req_rdy, 0);
        chk("rst_ll_req_vld", ll_req_vld, 0);
        chk("rst_host_resp_vld", host_resp_vld, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();
        chk("post_rst_req_rdy", host_req_rdy, 1);

        // Single write: issue 2 cycles after push, response 5 cycles after issue.
        ll_intf_ready = 1'b1;
        push(REQ_WRITE, 4'd0, 8'hA5, 4'd3);
        chk("t1_no_early_issue", ll_req_vld, 0);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_issue", ll_req_vld, 1);
        chk("t1_type", ll_req_type, REQ_WRITE);
        chk("t1_pos", ll_req_pos, 0);
        chk("t1_data", ll_req_data, 8'hA5);
        step();
        chk("t1_one_pulse", ll_req_vld, 0);
        repeat (4) step();
        ll_resp_vld = 1'b1; ll_resp_type = RESP_ADDR_ERR; ll_resp_data = 8'h5A; ll_resp_data_vld = 1'b1;
        #1;
        chk("t1_taken", ll_resp_taken, 1);
        step();
        ll_resp_vld = 1'b0; ll_resp_data_vld = 1'b0;
        #1;
        chk("t1_taken_drop", ll_resp_taken, 0);
        chk("t1_resp_vld", host_resp_vld, 1);
        chk("t1_resp_tag", host_resp_tag, 3);
        chk("t1_resp_type", host_resp_type, RESP_ADDR_ERR);
        chk("t1_resp_data", host_resp_data, 8'h5A);
        chk("t1_resp_dvld", host_resp_data_vld, 1);
        step();
        chk("t1_resp_done", host_resp_vld, 0);
        chk("t1_idle", busy, 0);

        // Fill with list not ready; the fifth push must be dropped.
        ll_intf_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(REQ_READ, PTR_WD'(i), 8'h10 + 8'(i), 4'(i));
        chk("t2_full_rdy", host_req_rdy, 0);
        push(REQ_READ, 4'hF, 8'hEE, 4'd9);
        chk("t2_still_full", host_req_rdy, 0);
        chk("t2_no_issue", ll_req_vld, 0);
        ll_intf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_issue("t2_issue");
            chk("t2_pos", ll_req_pos, i);
            chk("t2_data", ll_req_data, 8'h10 + 8'(i));
            step();
            respond(RESP_OK, 8'h80 + 8'(i));
            chk("t2_resp_vld", host_resp_vld, 1);
            chk("t2_resp_tag", host_resp_tag, i);
            chk("t2_resp_data", host_resp_data, 8'h80 + 8'(i));
        end
        repeat (3) step();
        chk("t2_dropped_5th", ll_req_vld, 0);
        chk("t2_drained", busy, 0);

        // Timeout: no response, host response 8 cycles after ISSUE.
        push(REQ_DELETE, 4'd2, 8'h21, 4'd5);
        wait_issue("t3_issue");
        repeat (7) step();
        chk("t3_not_yet", host_resp_vld, 0);
        step();
        chk("t3_resp_vld", host_resp_vld, 1);
        chk("t3_resp_type", host_resp_type, RESP_TIMEOUT);
        chk("t3_resp_data", host_resp_data, 0);
        chk("t3_resp_dvld", host_resp_data_vld, 0);
        chk("t3_resp_tag", host_resp_tag, 5);
        step();

        // Response in the timeout cycle wins.
        push(REQ_INSERT, 4'd1, 8'h31, 4'd6);
        wait_issue("t4_issue");
        repeat (7) step();
        respond(RESP_ERROR, 8'h33);
        chk("t4_resp_vld", host_resp_vld, 1);
        chk("t4_resp_type", host_resp_type, RESP_ERROR);
        chk("t4_resp_data", host_resp_data, 8'h33);
        chk("t4_resp_dvld", host_resp_data_vld, 1);
        chk("t4_resp_tag", host_resp_tag, 6);
        step();

        // Host backpressure holds the response and blocks the next issue.
        host_resp_rdy = 1'b0;
        push(REQ_WRITE, 4'd3, 8'h07, 4'd7);
        push(REQ_WRITE, 4'd4, 8'h08, 4'd8);
        wait_issue("t5_issue_a");
        chk("t5_pos_a", ll_req_pos, 3);
        step();
        respond(RESP_OK, 8'h44);
        for (int k = 0; k < 10; k++) begin
            chk("t5_hold_vld", host_resp_vld, 1);
            chk("t5_hold_tag", host_resp_tag, 7);
            chk("t5_hold_data", host_resp_data, 8'h44);
            chk("t5_no_issue", ll_req_vld, 0);
            step();
        end
        host_resp_rdy = 1'b1;
        step();
        chk("t5_idle_gap", ll_req_vld, 0);
        step();
        chk("t5_issue_b", ll_req_vld, 1);
        chk("t5_data_b", ll_req_data, 8'h08);
        step();
        respond(RESP_OK, 8'h45);
        chk("t5_resp_tag_b", host_resp_tag, 8);
        chk("t5_resp_data_b", host_resp_data, 8'h45);
        step();

        // Reset during WAIT with two entries queued.
        push(REQ_READ, 4'd5, 8'hA0, 4'd10);
        push(REQ_READ, 4'd6, 8'hA1, 4'd11);
        push(REQ_READ, 4'd7, 8'hA2, 4'd12);
        chk("t6_busy", busy, 1);
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_req_rdy", host_req_rdy, 0);
        chk("t6_rst_ll_req_vld", ll_req_vld, 0);
        chk("t6_rst_resp_vld", host_resp_vld, 0);
        chk("t6_rst_resp_tag", host_resp_tag, 0);
        chk("t6_rst_busy", busy, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t6_no_stale_issue", ll_req_vld, 0);
            chk("t6_no_stale_resp", host_resp_vld, 0);
        end
        push(REQ_WRITE, 4'd8, 8'h5C, 4'd13);
        chk("t6_no_early", ll_req_vld, 0);
        step();
        chk("t6_issue", ll_req_vld, 1);
        chk("t6_data", ll_req_data, 8'h5C);
        step();
        respond(RESP_OK, 8'h77);
        chk("t6_resp_tag", host_resp_tag, 13);
        chk("t6_resp_data", host_resp_data, 8'h77);
        step();

        // Stray response in IDLE is acknowledged and dropped.
        ll_resp_vld = 1'b1; ll_resp_type = RESP_ERROR;
        #1;
        chk("t7_taken", ll_resp_taken, 1);
        step();
        ll_resp_vld = 1'b0;
        #1;
        chk("t7_no_resp", host_resp_vld, 0);
        chk("t7_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
